// File: rtl/seg_pkg.sv
// seg_pkg: shared types and the hex-to-7-segment table for seg_display_scheduler.
//   state_t  : scheduler FSM states {IDLE, SHOW, GAP}
//   SEG_HEX  : gfedcba pattern per hex value 0..F
//   hex7seg  : table lookup helper
package seg_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex7seg(input logic [3:0] d);
        return SEG_HEX[d];
    endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// seg_display_scheduler_if: requester-side bundle of the display scheduler.
//   req   : per-requester request, held until ack or withdrawn
//   digit : digit[4*i+:4] is requester i's hex value
//   ack   : one-cycle pulse when requester i's slot ran to completion
//   grant : one-hot display owner, 0 when idle or in the gap
//   busy  : scheduler is in SHOW or GAP
//   SEG   : [6:0] gfedcba segments, [7] decimal point
// master = producers, slave = scheduler.
interface seg_display_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] digit;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        SEG;

    modport master (output req, digit, input ack, grant, busy, SEG);
    modport slave  (input req, digit, output ack, grant, busy, SEG);
endinterface

// File: rtl/seg_display_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot grant to the first set req at or after ptr (wrapping), 0 if none
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin time-sharing of one 7-segment display.
//   clk_2   : board clock
//   reset_n : asynchronous active-low reset
//   bus     : seg_display_scheduler_if.slave (req/digit in, ack/grant/busy/SEG out)
// Each winner owns the display for HOLD_CYCLES cycles, followed by GAP_CYCLES
// blank cycles. All outputs are registered.
// Build option: define SEG_BLINK_EN to blank SEG on odd counter values in SHOW.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                    clk_2,
    input  logic                    reset_n,
    seg_display_scheduler_if.slave  bus
);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(NREQ);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
`ifdef SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    // blank is the counter LSB for the cycle the word will be displayed in
    function automatic logic [7:0] seg_word(input logic [3:0] d, input logic dp,
                                            input logic blank);
        return (BLINK && blank) ? 8'h00 : {dp, hex7seg(d)};
    endfunction

    function automatic logic [PW-1:0] oh2idx(input logic [NREQ-1:0] oh);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) r = r | PW'(i);
        return r;
    endfunction

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   g_idx;
    logic [3:0]      dig_q;
    logic [NREQ-1:0] ack_q, grant_q;
    logic            busy_q;
    logic [7:0]      seg_q;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic [3:0]      arb_dig;
    logic            do_arb;
    logic [CW-1:0]   cnt_dec;
    logic [PW-1:0]   ptr_nxt;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    assign arb_idx = oh2idx(arb_gnt);
    assign arb_dig = bus.digit[{arb_idx, 2'b00} +: 4];
    assign do_arb  = (|bus.req) && (state == IDLE || (state == GAP && cnt == '0));
    assign cnt_dec = cnt - CW'(1);
    assign ptr_nxt = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            g_idx   <= '0;
            dig_q   <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            seg_q   <= '0;
        end else begin
            ack_q <= '0;
            if (do_arb) begin
                state   <= SHOW;
                cnt     <= HOLD_LD;
                dig_q   <= arb_dig;
                g_idx   <= arb_idx;
                grant_q <= arb_gnt;
                busy_q  <= 1'b1;
                seg_q   <= seg_word(arb_dig, |(bus.req & ~arb_gnt), HOLD_LD[0]);
                // single-cycle slot: the only SHOW cycle is also the ack cycle
                if (HOLD_LD == '0) ack_q <= arb_gnt;
            end else begin
                case (state)
                    SHOW: begin
                        // withdrawal is checked first so it suppresses a pending ack
                        if (!bus.req[g_idx] || cnt == '0) begin
                            state   <= GAP;
                            ptr     <= ptr_nxt;
                            cnt     <= GAP_LD;
                            grant_q <= '0;
                            seg_q   <= '0;
                        end else begin
                            cnt   <= cnt_dec;
                            seg_q <= seg_word(dig_q, |(bus.req & ~grant_q), cnt_dec[0]);
                            // ack lands in the final (counter==0) SHOW cycle
                            if (cnt_dec == '0) ack_q <= grant_q;
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                        seg_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.SEG   = seg_q;

endmodule
